// File: rtl/cmp_sweep_checker.sv
// Sweep-and-check engine for a W-bit magnitude comparator with one-hot r/g/bl indication.
// Drives every (a, b) pair, waits SETTLE cycles, then scores the comparator outputs.
module cmp_sweep_checker #(
   parameter int unsigned W      = 2,
   parameter int unsigned SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [W-1:0]     a_out,
   output logic [W-1:0]     b_out,
   input  logic             r_in,
   input  logic             g_in,
   input  logic             bl_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [2*W:0]     err_count,
   output logic             fail_valid,
   output logic [W-1:0]     fail_a,
   output logic [W-1:0]     fail_b,
   output logic [2:0]       fail_rgb
);

   localparam int unsigned IW = 2 * W;
   localparam int unsigned EW = 2 * W + 1;
   localparam int unsigned CW = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [EW-1:0] err_d;
   logic          armed_q;
   logic          busy_d, done_d, pass_d, fv_d;
   logic [W-1:0]  fa_d, fb_d;
   logic [2:0]    frgb_d;

   logic [W-1:0]  cur_a, cur_b;
   logic [2:0]    exp_rgb, obs_rgb;

   assign a_out = idx_q[IW-1:W];
   assign b_out = idx_q[W-1:0];

   // Blocks a start that arrives with the reset release edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed_q <= 1'b0;
      else        armed_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         err_count  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_rgb   <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         err_count  <= err_d;
         busy       <= busy_d;
         done       <= done_d;
         pass       <= pass_d;
         fail_valid <= fv_d;
         fail_a     <= fa_d;
         fail_b     <= fb_d;
         fail_rgb   <= frgb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_count;
      busy_d  = busy;
      done_d  = done;
      fv_d    = fail_valid;
      fa_d    = fail_a;
      fb_d    = fail_b;
      frgb_d  = fail_rgb;

      cur_a   = idx_q[IW-1:W];
      cur_b   = idx_q[W-1:0];
      exp_rgb = {cur_a > cur_b, cur_a == cur_b, cur_a < cur_b};
      obs_rgb = {r_in, g_in, bl_in};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && armed_q) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               fa_d    = '0;
               fb_d    = '0;
               frgb_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(SETTLE - 1)) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (obs_rgb != exp_rgb) begin
               err_d = err_count + EW'(1);
               if (!fail_valid) begin
                  fv_d   = 1'b1;
                  fa_d   = cur_a;
                  fb_d   = cur_b;
                  frgb_d = obs_rgb;
               end
            end
            if (idx_q == '1) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + IW'(1);
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pass_d = done_d && (err_d == '0);
   end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Directed bench for cmp_sweep_checker: golden and faulty comparator models, reset and start corners.
module tb_cmp_sweep_checker;

   localparam int unsigned W = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start1 = 1'b0;

   logic [W-1:0] a_out, b_out, fail_a, fail_b;
   logic         r_in, g_in, bl_in, busy, done, pass, fail_valid;
   logic [2*W:0] err_count;
   logic [2:0]   fail_rgb;

   logic [W-1:0] a1, b1, fa1, fb1;
   logic         r1, g1, bl1, busy1, done1, pass1, fv1;
   logic [2*W:0] err1;
   logic [2:0]   frgb1;

   int mode = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Comparator model with selectable faults: 0 good, 1 r stuck low, 2 r/bl swapped, 3 all high.
   always_comb begin
      logic gr, eq, ls;
      gr = a_out > b_out;
      eq = a_out == b_out;
      ls = a_out < b_out;
      r_in = gr; g_in = eq; bl_in = ls;
      case (mode)
         1: r_in = 1'b0;
         2: begin r_in = ls; bl_in = gr; end
         3: begin r_in = 1'b1; g_in = 1'b1; bl_in = 1'b1; end
         default: ;
      endcase
   end

   assign r1  = a1 > b1;
   assign g1  = a1 == b1;
   assign bl1 = a1 < b1;

   cmp_sweep_checker #(.W(W), .SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_out(a_out), .b_out(b_out),
      .r_in(r_in), .g_in(g_in), .bl_in(bl_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_rgb(fail_rgb)
   );

   cmp_sweep_checker #(.W(W), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .a_out(a1), .b_out(b1),
      .r_in(r1), .g_in(g1), .bl_in(bl1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_rgb(frgb1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_a"}, 32'(a_out), 0);
      chk({tag, "_b"}, 32'(b_out), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_err"}, 32'(err_count), 0);
      chk({tag, "_fv"}, 32'(fail_valid), 0);
      chk({tag, "_fab"}, 32'({fail_a, fail_b}), 0);
      chk({tag, "_frgb"}, 32'(fail_rgb), 0);
   endtask

   // Pulse start, follow the sweep to done, check stepping and total length.
   task automatic run_sweep(input string tag, input int extra);
      int n;
      int ab_bad;
      ab_bad = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      n = 0;
      chk({tag, "_busy_rise"}, 32'(busy), 1);
      chk({tag, "_cleared"}, 32'({done, fail_valid, err_count}), 0);
      while (!done && n < 200) begin
         if (n == extra) start = 1'b1;
         @(posedge clk);
         n++;
         @(negedge clk) start = 1'b0;
         if (!done && {a_out, b_out} != 4'(n / 3)) ab_bad++;
      end
      chk({tag, "_cycles"}, 32'(n), 48);
      chk({tag, "_ab_seq"}, 32'(ab_bad), 0);
      chk({tag, "_busy_fall"}, 32'(busy), 0);
   endtask

   typedef struct {
      string      name;
      int         mode;
      int         extra;
      int         err;
      logic       fv;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [2:0] rgb;
      logic       pass;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int n;
      vecs[0] = '{"golden",    0, -1,  0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1};
      vecs[1] = '{"r_stuck0",  1, -1,  6, 1'b1, 2'd1, 2'd0, 3'b000, 1'b0};
      vecs[2] = '{"swap_r_bl", 2, -1, 12, 1'b1, 2'd0, 2'd1, 3'b100, 1'b0};
      vecs[3] = '{"all_high",  3, -1, 16, 1'b1, 2'd0, 2'd0, 3'b111, 1'b0};
      vecs[4] = '{"busy_start",0, 10,  0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1};

      repeat (3) @(negedge clk);
      chk_reset_state("por");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         run_sweep(vecs[i].name, vecs[i].extra);
         chk({vecs[i].name, "_err"}, 32'(err_count), 32'(vecs[i].err));
         chk({vecs[i].name, "_fv"}, 32'(fail_valid), 32'(vecs[i].fv));
         chk({vecs[i].name, "_fa"}, 32'(fail_a), 32'(vecs[i].fa));
         chk({vecs[i].name, "_fb"}, 32'(fail_b), 32'(vecs[i].fb));
         chk({vecs[i].name, "_frgb"}, 32'(fail_rgb), 32'(vecs[i].rgb));
         chk({vecs[i].name, "_pass"}, 32'(pass), 32'(vecs[i].pass));
         chk({vecs[i].name, "_done"}, 32'(done), 1);
      end

      // Reset mid-sweep: six vectors already scored as failures at cycle 20.
      mode = 3;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      repeat (19) @(posedge clk);
      #1 chk("mid_err", 32'(err_count), 6);
      #1 rst_n = 1'b0;
      #1 chk_reset_state("async_rst");
      @(negedge clk) rst_n = 1'b1;
      mode = 0;
      run_sweep("after_rst", -1);
      chk("after_rst_err", 32'(err_count), 0);
      chk("after_rst_pass", 32'(pass), 1);

      // Start held across reset release must not launch a sweep.
      @(negedge clk) begin rst_n = 1'b0; start = 1'b1; end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rel_start_busy", 32'(busy), 0);
      chk("rel_start_done", 32'(done), 0);

      // SETTLE = 1 instance: two cycles per vector.
      @(negedge clk) start1 = 1'b1;
      @(posedge clk);
      @(negedge clk) start1 = 1'b0;
      n = 0;
      while (!done1 && n < 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("s1_cycles", 32'(n), 32);
      chk("s1_pass", 32'(pass1), 1);
      chk("s1_err", 32'(err1), 0);
      chk("s1_fv", 32'({fv1, fa1, fb1, frgb1, busy1}), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmp_sweep_checker.md
# cmp_sweep_checker

Self-contained hardware sweep-and-check engine for the lab5 2-bit magnitude comparator with RGB indication. On a start pulse it drives every (a, b) operand combination into the comparator. For each vector it waits a programmable settle time, samples the comparator's r/g/bl outputs and checks them against the expected one-hot result. It reports an error count, the first failing vector and a pass/done status, which lets the comparator be verified on the board without a simulator.

## Interface
- W, 2: operand width in bits; the sweep covers 2^(2W) vectors.
- SETTLE, 2: cycles between a driven vector and its check; legal range 1..15.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
- a_out  output  W  operand a to comparator (registered).
- b_out  output  W  operand b to comparator (registered).
- r_in  input  1  comparator r output; expected 1 iff a > b.
- g_in  input  1  comparator g output; expected 1 iff a == b.
- bl_in  input  1  comparator bl output; expected 1 iff a < b.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until next start or reset.
- pass  output  1  done && err_count == 0.
- err_count  output  2W+1  number of failing vectors in the current/last sweep.
- fail_valid  output  1  high once a first failure has been captured.
- fail_a, fail_b  output  W each  operands of the first failing vector.
- fail_rgb  output  3  {r_in, g_in, bl_in} sampled at the first failure.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Vector index idx is 2W bits wide; a_out = idx[2W-1:W] and b_out = idx[W-1:0]. b is the fastest-moving operand.
- Expected value is exp = {a>b, a==b, a<b}, treated as unsigned. A vector fails if {r_in, g_in, bl_in} != exp. Non-one-hot patterns, including all-zero and all-one, therefore count as failures.
- IDLE/DONE + start:
  - Clear idx, err_count, fail_valid, fail_a, fail_b and fail_rgb.
  - Drive a_out = b_out = 0 and set cnt = 0.
  - Go to SETTLE.
- SETTLE: increment cnt each cycle; when cnt == SETTLE-1, go to CHECK.
- CHECK: sample the inputs and compare against exp.
  - On failure, increment err_count. If fail_valid is 0, also capture fail_a/fail_b/fail_rgb and set fail_valid.
  - If idx is all-ones, go to DONE.
  - Otherwise increment idx, update a_out/b_out on the same edge, clear cnt and go to SETTLE.
- DONE: hold all result outputs; busy = 0, done = 1.
- start while busy is ignored, with no restart and no effect on counters.
- err_count cannot overflow because its maximum value 2^(2W) fits in 2W+1 bits.

## Timing
- Reset values: state = IDLE, a_out = b_out = 0, busy = done = pass = 0, err_count = 0, fail_valid = 0, fail_a = fail_b = 0, fail_rgb = 0.
- Per-vector cost: SETTLE + 1 cycles (SETTLE cycles of settle, then 1 check cycle).
- Full sweep: 2^(2W)·(SETTLE+1) cycles from the start edge to the edge that sets done. For the defaults this is 16·3 = 48 cycles.
- busy rises on the edge that samples start and falls on the edge that sets done.
- Vector k is driven from edge k·(SETTLE+1) after start.
- The comparator's combinational path must settle within SETTLE-1 full cycles plus one cycle.
- Inputs are sampled on the rising edge that ends the CHECK cycle; no input synchronisation is performed.
- Reset asserted mid-sweep immediately forces every output to its reset value, independent of clk. No partial results are retained.
- A start coinciding with reset release is ignored.

## Test plan
- Golden comparator model, defaults, start pulse → a_out/b_out step through 00/00…11/11 every 3 cycles; done = pass = 1 at cycle 48; err_count = 0; fail_valid = 0.
- r_in stuck at 0 → err_count = 6; fail_a = 1, fail_b = 0, fail_rgb = 3'b000; pass = 0.
- r_in and bl_in swapped → err_count = 12; first failure fail_a = 0, fail_b = 1, fail_rgb = 3'b100.
- All three inputs tied high → err_count = 16; fail_a = fail_b = 0; fail_rgb = 3'b111.
- Reset pulsed at cycle 20 of a sweep → all outputs return to reset values asynchronously. A new start then completes in 48 cycles with correct results.
- start pulsed at cycle 10 (busy) → ignored, done still at cycle 48. start in DONE → err_count/fail_* cleared and a new 48-cycle sweep runs. Repeat the golden run with SETTLE = 1 → done at cycle 32.
